// File: rtl/complex_addsub_arbiter.sv
// Round-robin sharing of one pipelined complex adder/subtractor between two requesters.
// A tag pipeline matched to the adder latency steers each result back to its issuer.
module complex_addsub_arbiter #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_op,
  output logic             adder_ce,
  input  logic [WIDTH-1:0] adder_result,
  output logic             busy,
  output logic [4:0]       outstanding0,
  output logic [4:0]       outstanding1
);

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  req_id_t          last;
  req_id_t          grant_id;
  logic             grant0;
  logic             grant1;
  logic             accept0;
  logic             accept1;
  logic             accept;
  logic             done0;
  logic             done1;
  logic [LATENCY:0] tag_vld;
  req_id_t          tag_id [LATENCY+1];

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !hold) begin
      if (req0_valid && req1_valid) begin
        grant0 = (last == REQ1);
        grant1 = (last == REQ0);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept0    = req0_valid & grant0;
  assign accept1    = req1_valid & grant1;
  assign accept     = accept0 | accept1;
  assign grant_id   = accept1 ? REQ1 : REQ0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= REQ1;
    end else if (accept) begin
      last <= grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adder_a  <= '0;
      adder_b  <= '0;
      adder_op <= 1'b0;
      adder_ce <= 1'b0;
    end else begin
      adder_ce <= 1'b1;
      if (accept1) begin
        adder_a  <= req1_a;
        adder_b  <= req1_b;
        adder_op <= req1_op;
      end else if (accept0) begin
        adder_a  <= req0_a;
        adder_b  <= req0_b;
        adder_op <= req0_op;
      end
    end
  end

  // Stage LATENCY lines up with adder_result for the op issued LATENCY+1 edges earlier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        tag_id[i] <= REQ0;
      end
    end else begin
      tag_vld   <= {tag_vld[LATENCY-1:0], accept};
      tag_id[0] <= grant_id;
      for (int unsigned i = 1; i <= LATENCY; i++) begin
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign done0 = tag_vld[LATENCY] && (tag_id[LATENCY] == REQ0);
  assign done1 = tag_vld[LATENCY] && (tag_id[LATENCY] == REQ1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= done0;
      rsp1_valid <= done1;
      if (done0) begin
        rsp0_data <= adder_result;
      end
      if (done1) begin
        rsp1_data <= adder_result;
      end
    end
  end

  // Counters track tags still inside the pipe, so they top out at LATENCY+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding0 <= '0;
      outstanding1 <= '0;
    end else begin
      case ({accept0, done0})
        2'b10:   outstanding0 <= outstanding0 + 5'd1;
        2'b01:   outstanding0 <= outstanding0 - 5'd1;
        default: outstanding0 <= outstanding0;
      endcase
      case ({accept1, done1})
        2'b10:   outstanding1 <= outstanding1 + 5'd1;
        2'b01:   outstanding1 <= outstanding1 - 5'd1;
        default: outstanding1 <= outstanding1;
      endcase
    end
  end

  assign busy = (|tag_vld) | rsp0_valid | rsp1_valid | grant0 | grant1;

endmodule
